// File: rtl/codificador_instrucao_pkg.sv
// Shared constants for the instruction encoder: RV32 opcodes, run states and error codes.
package codificador_instrucao_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NENHUM = 2'b00;
  localparam logic [1:0] ERR_OPCODE = 2'b01;
  localparam logic [1:0] ERR_IMM    = 2'b10;
  localparam logic [1:0] ERR_IMPAR  = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARGA   = 2'd1,
    ESVAZIA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  // True when every bit above the sign bit of a 'bits'-wide field is a copy of it.
  function automatic logic cabe_com_sinal(input logic [31:0] valor, input int unsigned bits);
    logic [31:0] topo;
    topo = valor >> (bits - 1);
    return (topo == 32'd0) || (topo == (32'hFFFF_FFFF >> (bits - 1)));
  endfunction

endpackage

// File: rtl/codificador_instrucao_if.sv
// Field-bundle input stream and instruction-memory write port of the encoder.
interface codificador_instrucao_if #(
  parameter int AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/codificador_instrucao_campos.sv
// Combinational packing of decoded fields into an RV32 R/I(load)/S/B word, with immediate checks.
module codificador_campos
  import codificador_instrucao_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] palavra,
  output logic [1:0]  err_cod
);

  always_comb begin
    palavra = '0;
    err_cod = ERR_NENHUM;
    case (opcode)
      OP_R: palavra = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_LOAD: begin
        palavra = {imm[11:0], rs1, funct3, rd, opcode};
        if (!cabe_com_sinal(imm, 12)) err_cod = ERR_IMM;
      end
      OP_STORE: begin
        palavra = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!cabe_com_sinal(imm, 12)) err_cod = ERR_IMM;
      end
      OP_BRANCH: begin
        palavra = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        // Parity first: for even offsets the 13-bit signed fit is exactly -4096..4094.
        if (imm[0]) err_cod = ERR_IMPAR;
        else if (!cabe_com_sinal(imm, 13)) err_cod = ERR_IMM;
      end
      default: err_cod = ERR_OPCODE;
    endcase
  end

endmodule

// File: rtl/codificador_instrucao.sv
// Instruction encoder: consumes num_instr field bundles and writes encoded words from end_base upward.
//   state   | meaning
//   OCIOSO  | idle, waiting for iniciar
//   CARGA   | accepting bundles until num_instr have been consumed
//   ESVAZIA | all bundles consumed, draining the stage register
//   FIM     | one-cycle completion (concluido)
module codificador_instrucao
  import codificador_instrucao_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iniciar,
  input  logic [AW-1:0]          end_base,
  input  logic [CW-1:0]          num_instr,
  codificador_instrucao_if.slave bus,
  output logic                   ocupado,
  output logic                   concluido,
  output logic                   erro,
  output logic [1:0]             erro_cod
);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [AW-1:0] end_q, end_d;
  logic          stage_valid_q, stage_valid_d;
  logic [31:0]   stage_palavra_q, stage_palavra_d;
  logic          erro_q, erro_d;
  logic [1:0]    erro_cod_q, erro_cod_d;

  logic [31:0]   palavra;
  logic [1:0]    cod_campos;
  logic          in_ready_int;
  logic          aceita;
  logic          retira;

  codificador_campos u_campos (
    .opcode  (bus.in_opcode),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .imm     (bus.in_imm),
    .palavra (palavra),
    .err_cod (cod_campos)
  );

  assign in_ready_int = (estado_q == CARGA) && (!stage_valid_q || bus.mem_ready);
  assign aceita       = bus.in_valid && in_ready_int;
  assign retira       = stage_valid_q && bus.mem_ready;

  always_comb begin
    estado_d        = estado_q;
    num_d           = num_q;
    cont_d          = cont_q;
    end_d           = end_q;
    stage_valid_d   = stage_valid_q;
    stage_palavra_d = stage_palavra_q;
    erro_d          = erro_q;
    erro_cod_d      = erro_cod_q;

    if (retira) begin
      stage_valid_d = 1'b0;
      end_d         = end_q + AW'(4);
    end

    // A rejected bundle still counts, but leaves the stage register as the retire left it.
    if (aceita) begin
      cont_d = cont_q + CW'(1);
      if (cod_campos != ERR_NENHUM) begin
        erro_d = 1'b1;
        if (!erro_q) erro_cod_d = cod_campos;
      end else begin
        stage_valid_d   = 1'b1;
        stage_palavra_d = palavra;
      end
    end

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          num_d      = num_instr;
          cont_d     = '0;
          end_d      = end_base & ~AW'(3);
          erro_d     = 1'b0;
          erro_cod_d = ERR_NENHUM;
          estado_d   = (num_instr == '0) ? FIM : CARGA;
        end
      end
      CARGA:   if (aceita && (cont_d == num_q)) estado_d = ESVAZIA;
      ESVAZIA: if (!stage_valid_q) estado_d = FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q        <= OCIOSO;
      num_q           <= '0;
      cont_q          <= '0;
      end_q           <= '0;
      stage_valid_q   <= 1'b0;
      stage_palavra_q <= '0;
      erro_q          <= 1'b0;
      erro_cod_q      <= ERR_NENHUM;
    end else begin
      estado_q        <= estado_d;
      num_q           <= num_d;
      cont_q          <= cont_d;
      end_q           <= end_d;
      stage_valid_q   <= stage_valid_d;
      stage_palavra_q <= stage_palavra_d;
      erro_q          <= erro_d;
      erro_cod_q      <= erro_cod_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.mem_we    = stage_valid_q;
  assign bus.mem_addr  = end_q;
  assign bus.mem_wdata = stage_palavra_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign concluido     = (estado_q == FIM);
  assign erro          = erro_q;
  assign erro_cod      = erro_cod_q;

endmodule

// File: tb/tb_codificador_instrucao.sv
// Self-checking bench for codificador_instrucao: directed scenarios plus randomized runs against a reference model.
module tb_codificador_instrucao;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iniciar;
  logic [31:0] end_base;
  logic [15:0] num_instr;
  logic        ocupado, concluido, erro;
  logic [1:0]  erro_cod;

  codificador_instrucao_if #(.AW(32)) bus ();

  codificador_instrucao #(.AW(32), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iniciar   (iniciar),
    .end_base  (end_base),
    .num_instr (num_instr),
    .bus       (bus.slave),
    .ocupado   (ocupado),
    .concluido (concluido),
    .erro      (erro),
    .erro_cod  (erro_cod)
  );

  always #5 clk = ~clk;

  int erros  = 0;
  int checks = 0;
  int ciclo  = 0;
  bit pronto_aleatorio = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          c;
  } escrita_t;

  escrita_t    obs_q[$];
  escrita_t    exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_erro;
  logic [1:0]  exp_cod;

  always @(posedge clk) ciclo <= ciclo + 1;

  always @(negedge clk) begin
    escrita_t e;
    if (rst_n && bus.mem_we && bus.mem_ready) begin
      e.addr = bus.mem_addr;
      e.word = bus.mem_wdata;
      e.c    = ciclo;
      obs_q.push_back(e);
    end
  end

  always @(posedge clk) begin
    if (pronto_aleatorio) begin
      #1;
      bus.mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference encoding built from the field layout with plain shifts and arithmetic.
  task automatic modelo(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, output logic [31:0] w, output logic [1:0] e);
    logic [31:0] o, d, s1, s2, k3, k7, u;
    int s;
    o = 32'(op); d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); k3 = 32'(f3); k7 = 32'(f7);
    s = $signed(imm);
    w = 32'd0;
    e = 2'd0;
    case (op)
      7'h33: w = o + (d << 7) + (k3 << 12) + (s1 << 15) + (s2 << 20) + (k7 << 25);
      7'h03: begin
        if (s < -2048 || s > 2047) e = 2'd2;
        else begin
          u = imm & 32'hFFF;
          w = o + (d << 7) + (k3 << 12) + (s1 << 15) + (u << 20);
        end
      end
      7'h23: begin
        if (s < -2048 || s > 2047) e = 2'd2;
        else begin
          u = imm & 32'hFFF;
          w = o + ((u % 32) << 7) + (k3 << 12) + (s1 << 15) + (s2 << 20) + ((u / 32) << 25);
        end
      end
      7'h63: begin
        if (s % 2 != 0) e = 2'd3;
        else if (s < -4096 || s > 4094) e = 2'd2;
        else begin
          u = imm & 32'h1FFF;
          w = o + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (k3 << 12) + (s1 << 15)
                + (s2 << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
        end
      end
      default: e = 2'd1;
    endcase
  endtask

  task automatic iniciar_run(input logic [31:0] base, input logic [15:0] n);
    obs_q.delete();
    exp_q.delete();
    exp_addr = base & ~32'd3;
    exp_erro = 1'b0;
    exp_cod  = 2'd0;
    end_base  = base;
    num_instr = n;
    iniciar   = 1'b1;
    @(posedge clk); #1;
    iniciar   = 1'b0;
  endtask

  task automatic enviar(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
    bit ok = 1'b0;
    logic [31:0] w;
    logic [1:0]  e;
    escrita_t    x;
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++; erros++;
      $display("FAIL handshake: in_ready stayed 0, required 1 within 300 cycles");
    end
    modelo(op, rd, rs1, rs2, f3, f7, imm, w, e);
    if (e == 2'd0) begin
      x.addr = exp_addr; x.word = w; x.c = 0;
      exp_q.push_back(x);
      exp_addr = exp_addr + 32'd4;
    end else begin
      if (!exp_erro) exp_cod = e;
      exp_erro = 1'b1;
    end
  endtask

  task automatic aguardar_fim();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (concluido) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; erros++;
      $display("FAIL fim: concluido stayed 0, required 1 within 500 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.mem_we, bus.in_ready, ocupado, concluido, erro, erro_cod} !== 7'd0) begin
      erros++; $display("FAIL reset_flags: got %b required 0", {bus.mem_we, bus.in_ready, ocupado, concluido, erro, erro_cod});
    end
    checks++;
    if (bus.mem_addr !== 32'd0) begin erros++; $display("FAIL reset_addr: got %h required 0", bus.mem_addr); end
    checks++;
    if (bus.mem_wdata !== 32'd0) begin erros++; $display("FAIL reset_wdata: got %h required 0", bus.mem_wdata); end
  endtask

  task automatic test_r_unico();
    bus.mem_ready = 1'b1;
    iniciar_run(32'h100, 16'd1);
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    aguardar_fim();
    checks++;
    if (obs_q.size() != 1) begin erros++; $display("FAIL r_unico_count: got %0d required 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0].addr !== 32'h100 || obs_q[0].word !== 32'h002081B3) begin
        erros++; $display("FAIL r_unico_write: got %h@%h required 002081b3@00000100", obs_q[0].word, obs_q[0].addr);
      end
    end
    checks++;
    if (erro !== 1'b0) begin erros++; $display("FAIL r_unico_erro: got %b required 0", erro); end
    checks++;
    if (concluido !== 1'b0 || ocupado !== 1'b0) begin
      erros++; $display("FAIL r_unico_pulso: concluido=%b ocupado=%b required 0 0", concluido, ocupado);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pal[4];
    pal[0] = 32'h00812283; pal[1] = 32'hFE612E23; pal[2] = 32'hFE208CE3; pal[3] = 32'h002081B3;
    bus.mem_ready = 1'b1;
    iniciar_run(32'h0, 16'd4);
    enviar(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8);
    enviar(7'h23, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'hFFFF_FFFC);
    enviar(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8);
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    aguardar_fim();
    checks++;
    if (obs_q.size() != 4) begin erros++; $display("FAIL b2b_count: got %0d required 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].word !== pal[i] || obs_q[i].addr !== 32'(4 * i) || obs_q[i].c != obs_q[0].c + i) begin
          erros++;
          $display("FAIL b2b_write%0d: got %h@%h cycle+%0d required %h@%h cycle+%0d",
                   i, obs_q[i].word, obs_q[i].addr, obs_q[i].c - obs_q[0].c, pal[i], 32'(4 * i), i);
        end
      end
    end
  endtask

  task automatic test_contrapressao();
    logic [31:0] pal[3];
    pal[0] = 32'h00812283; pal[1] = 32'hFE612E23; pal[2] = 32'h002081B3;
    bus.mem_ready = 1'b1;
    iniciar_run(32'h80, 16'd3);
    enviar(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8);
    enviar(7'h23, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'hFFFF_FFFC);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_wdata !== pal[1] || bus.mem_addr !== 32'h84) begin
        erros++;
        $display("FAIL stall%0d: ready=%b we=%b %h@%h required 0 1 %h@00000084",
                 i, bus.in_ready, bus.mem_we, bus.mem_wdata, bus.mem_addr, pal[1]);
      end
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    aguardar_fim();
    checks++;
    if (obs_q.size() != 3) begin erros++; $display("FAIL stall_count: got %0d required 3", obs_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].word !== pal[i] || obs_q[i].addr !== 32'h80 + 32'(4 * i)) begin
          erros++; $display("FAIL stall_write%0d: got %h@%h required %h@%h", i, obs_q[i].word, obs_q[i].addr, pal[i], 32'h80 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_erros();
    bus.mem_ready = 1'b1;
    iniciar_run(32'h0, 16'd3);
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    enviar(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4096);
    enviar(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    aguardar_fim();
    checks++;
    if (obs_q.size() != 2 || obs_q[0].addr !== 32'h0 || obs_q[1].addr !== 32'h4) begin
      erros++; $display("FAIL err_imm_writes: got %0d writes required 2 at 0 and 4", obs_q.size());
    end
    checks++;
    if (erro !== 1'b1 || erro_cod !== 2'b10) begin erros++; $display("FAIL err_imm: got %b/%b required 1/10", erro, erro_cod); end

    iniciar_run(32'h0, 16'd1);
    checks++;
    if (erro !== 1'b0 || erro_cod !== 2'b00) begin erros++; $display("FAIL err_clear: got %b/%b required 0/00", erro, erro_cod); end
    enviar(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    aguardar_fim();
    checks++;
    if (erro !== 1'b1 || erro_cod !== 2'b01 || obs_q.size() != 0) begin
      erros++; $display("FAIL err_opcode: got %b/%b writes=%0d required 1/01 writes=0", erro, erro_cod, obs_q.size());
    end

    iniciar_run(32'h0, 16'd1);
    enviar(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    aguardar_fim();
    checks++;
    if (erro !== 1'b1 || erro_cod !== 2'b11 || obs_q.size() != 0) begin
      erros++; $display("FAIL err_impar: got %b/%b writes=%0d required 1/11 writes=0", erro, erro_cod, obs_q.size());
    end

    iniciar_run(32'h0, 16'd2);
    enviar(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    enviar(7'h23, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_F000);
    aguardar_fim();
    checks++;
    if (erro_cod !== 2'b01) begin erros++; $display("FAIL err_primeiro: got %b required 01", erro_cod); end
  endtask

  task automatic test_zero();
    iniciar_run(32'h40, 16'd0);
    @(negedge clk);
    checks++;
    if (concluido !== 1'b1) begin erros++; $display("FAIL zero_fim: concluido got %b required 1", concluido); end
    @(negedge clk);
    checks++;
    if (concluido !== 1'b0 || ocupado !== 1'b0 || obs_q.size() != 0) begin
      erros++; $display("FAIL zero_apos: concluido=%b ocupado=%b writes=%0d required 0 0 0", concluido, ocupado, obs_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_meio();
    bus.mem_ready = 1'b0;
    iniciar_run(32'h40, 16'd2);
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1) begin erros++; $display("FAIL rst_pre: mem_we got %b required 1", bus.mem_we); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || ocupado !== 1'b0 || bus.mem_addr !== 32'd0 || bus.in_ready !== 1'b0) begin
      erros++; $display("FAIL rst_meio: we=%b ocupado=%b addr=%h ready=%b required 0 0 0 0", bus.mem_we, ocupado, bus.mem_addr, bus.in_ready);
    end
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin erros++; $display("FAIL rst_sem_escrita: got %0d writes required 0", obs_q.size()); end
    @(posedge clk); #1;
    iniciar_run(32'h200, 16'd1);
    enviar(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    aguardar_fim();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 32'h200 || obs_q[0].word !== 32'h002081B3) begin
      erros++; $display("FAIL rst_nova_run: got %0d writes required 1 of 002081b3@00000200", obs_q.size());
    end
  endtask

  task automatic test_aleatorio();
    logic [31:0] base;
    logic [15:0] n;
    logic [6:0]  op;
    logic [31:0] imm;
    int          v;
    int          sel;
    pronto_aleatorio = 1'b1;
    for (int r = 0; r < 8; r++) begin
      base = (r == 0) ? 32'hFFFF_FFF9 : $urandom;
      n = 16'($urandom_range(1, 12));
      iniciar_run(base, n);
      for (int k = 0; k < int'(n); k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2: op = 7'h33;
          3, 4:    op = 7'h03;
          5, 6:    op = 7'h23;
          7, 8:    op = 7'h63;
          default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0:       v = int'($urandom_range(0, 4095)) - 2048;
          1:       v = int'($urandom_range(0, 8191)) - 4096;
          2:       v = int'($urandom_range(0, 20)) - 10;
          default: v = int'($urandom);
        endcase
        if (op == 7'h63 && $urandom_range(0, 3) != 0) v = v & ~1;
        imm = v;
        enviar(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
      end
      aguardar_fim();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        erros++; $display("FAIL rand%0d_count: got %0d writes required %0d", r, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].word !== exp_q[i].word) begin
            erros++; $display("FAIL rand%0d_write%0d: got %h@%h required %h@%h", r, i, obs_q[i].word, obs_q[i].addr, exp_q[i].word, exp_q[i].addr);
          end
        end
      end
      checks++;
      if (erro !== exp_erro || erro_cod !== exp_cod) begin
        erros++; $display("FAIL rand%0d_erro: got %b/%b required %b/%b", r, erro, erro_cod, exp_erro, exp_cod);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", erros + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iniciar = 1'b0; end_base = '0; num_instr = '0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.mem_ready = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_r_unico();
    test_back_to_back();
    test_contrapressao();
    test_erros();
    test_zero();
    test_reset_meio();
    test_aleatorio();
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
